// File: rtl/ex_divider_param.sv
// Iterative restoring divider for EX1: BITS_PER_CYCLE quotient bits per CALC cycle,
// optional early-out for divide-by-zero and |dividend| < |divisor|, sign fixup on entry to DONE.
module ex_divider_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush_exception,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             stall_divider,
  output logic             ready
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_q, r_raw;
  logic             r_qneg, r_rneg, r_dz;

  logic             w_accept, w_early, w_div_zero;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH+1:0] w_sh, w_d1;
  logic [WIDTH-1:0] w_rem_nx, w_q_raw, w_q_fin, w_r_fin;
  logic [BPC-1:0]   w_qbits;

  assign w_accept      = (r_state == IDLE) && en && !flush_exception;
  assign stall_divider = !rst && (w_accept || (r_state == CALC));

  assign w_abs_a    = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_abs_b    = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_early    = (EARLY_OUT != 0) && (w_div_zero || (w_abs_a < w_abs_b));

  // Partial remainder is always < divisor, so two guard bits cover 3*divisor.
  assign w_sh = (WIDTH+2)'({r_rem, r_dvd[WIDTH-1 -: BPC]});
  assign w_d1 = {2'b00, r_dvs};

  generate
    if (BPC == 1) begin : g_radix2
      always_comb begin
        w_qbits  = 1'b0;
        w_rem_nx = w_sh[WIDTH-1:0];
        if (w_sh >= w_d1) begin
          w_qbits  = 1'b1;
          w_rem_nx = WIDTH'(w_sh - w_d1);
        end
      end
    end else begin : g_radix4
      logic [WIDTH+1:0] w_d2, w_d3;
      assign w_d2 = w_d1 << 1;
      assign w_d3 = w_d2 + w_d1;
      always_comb begin
        w_qbits  = 2'd0;
        w_rem_nx = w_sh[WIDTH-1:0];
        if (w_sh >= w_d3) begin
          w_qbits  = 2'd3;
          w_rem_nx = WIDTH'(w_sh - w_d3);
        end else if (w_sh >= w_d2) begin
          w_qbits  = 2'd2;
          w_rem_nx = WIDTH'(w_sh - w_d2);
        end else if (w_sh >= w_d1) begin
          w_qbits  = 2'd1;
          w_rem_nx = WIDTH'(w_sh - w_d1);
        end
      end
    end
  endgenerate

  assign w_q_raw = (r_q << BPC) | WIDTH'(w_qbits);
  assign w_q_fin = r_dz ? '1    : (r_qneg ? -w_q_raw  : w_q_raw);
  assign w_r_fin = r_dz ? r_raw : (r_rneg ? -w_rem_nx : w_rem_nx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_raw     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ready     <= 1'b0;
    end else if (flush_exception) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          ready <= 1'b0;
          if (en) begin
            r_dvd  <= w_abs_a;
            r_dvs  <= w_abs_b;
            r_rem  <= '0;
            r_q    <= '0;
            r_raw  <= dividend;
            r_qneg <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_rneg <= sign & dividend[WIDTH-1];
            r_dz   <= w_div_zero;
            r_cnt  <= CW'(N);
            if (w_early) begin
              r_state   <= DONE;
              ready     <= 1'b1;
              quotient  <= w_div_zero ? '1 : '0;
              remainder <= dividend;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_dvd <= r_dvd << BPC;
          r_rem <= w_rem_nx;
          r_q   <= w_q_raw;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state   <= DONE;
            ready     <= 1'b1;
            quotient  <= w_q_fin;
            remainder <= w_r_fin;
          end
        end
        DONE: begin
          ready   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_divider_param.sv
// Directed bench for ex_divider_param across four parameterisations sharing one clock.
module tb_ex_divider_param;

  logic        clk = 1'b0;
  logic        rst, fl, sg;
  logic [3:0]  en_v;
  logic [31:0] a32, b32;
  logic [63:0] a64, b64;
  logic [31:0] q0, r0, q1, r1, q2, r2;
  logic [63:0] q3, r3;
  logic        st0, st1, st2, st3, rd0, rd1, rd2, rd3;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur     = 0;
  logic [63:0] o_q, o_r;
  logic        o_st, o_rd;

  always #5 clk = ~clk;

  ex_divider_param #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) u_d0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .flush_exception(fl), .sign(sg),
    .dividend(a32), .divisor(b32), .quotient(q0), .remainder(r0),
    .stall_divider(st0), .ready(rd0));
  ex_divider_param #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(0)) u_d1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .flush_exception(fl), .sign(sg),
    .dividend(a32), .divisor(b32), .quotient(q1), .remainder(r1),
    .stall_divider(st1), .ready(rd1));
  ex_divider_param #(.WIDTH(32), .BITS_PER_CYCLE(2), .EARLY_OUT(1)) u_d2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .flush_exception(fl), .sign(sg),
    .dividend(a32), .divisor(b32), .quotient(q2), .remainder(r2),
    .stall_divider(st2), .ready(rd2));
  ex_divider_param #(.WIDTH(64), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) u_d3 (
    .clk(clk), .rst(rst), .en(en_v[3]), .flush_exception(fl), .sign(sg),
    .dividend(a64), .divisor(b64), .quotient(q3), .remainder(r3),
    .stall_divider(st3), .ready(rd3));

  always_comb begin
    o_q = '0; o_r = '0; o_st = 1'b0; o_rd = 1'b0;
    case (cur)
      0: begin o_q = {32'b0, q0}; o_r = {32'b0, r0}; o_st = st0; o_rd = rd0; end
      1: begin o_q = {32'b0, q1}; o_r = {32'b0, r1}; o_st = st1; o_rd = rd1; end
      2: begin o_q = {32'b0, q2}; o_r = {32'b0, r2}; o_st = st2; o_rd = rd2; end
      3: begin o_q = q3; o_r = r3; o_st = st3; o_rd = rd3; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge, holds en until ready, checks latency/stall/results, leaves one idle cycle.
  task automatic do_div(input int id, input logic s, input logic [63:0] a, input logic [63:0] b,
                        input int elat, input logic [63:0] eq, input logic [63:0] er, input string tag);
    int lat, stc;
    cur = id; sg = s;
    a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b;
    en_v = 4'b0; en_v[id] = 1'b1;
    #1;
    stc = o_st ? 1 : 0;
    lat = 0;
    while (!o_rd && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (o_st) stc++;
    end
    en_v = 4'b0;
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " stall cycles"}, 64'(stc), 64'(elat));
    chk({tag, " quotient"}, o_q, eq);
    chk({tag, " remainder"}, o_r, er);
    @(negedge clk);
  endtask

  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
    logic signed [31:0] sa, sb;
    logic [31:0] ma, mb;
    sa = a; sb = b;
    ma = (s && a[31]) ? 32'(-a) : a;
    mb = (s && b[31]) ? 32'(-b) : b;
    if (b == 32'd0) begin
      q = '1; r = a; lat = 1;
    end else if (ma < mb) begin
      q = '0; r = a; lat = 1;
    end else begin
      lat = 17;
      if (!s) begin
        q = a / b; r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = '0;
      end else begin
        q = sa / sb; r = sa % sb;
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rq, rr;
    logic        rs;
    int          rl;
    bit          seen;

    rst = 1'b1; fl = 1'b0; sg = 1'b0; en_v = 4'b0001;
    a32 = 32'd100; b32 = 32'd7; a64 = '0; b64 = '0;
    #2;
    chk("reset quotient", {32'b0, q0}, 64'd0);
    chk("reset remainder", {32'b0, r0}, 64'd0);
    chk("reset ready", {63'b0, rd0}, 64'd0);
    chk("reset stall with en", {63'b0, st0}, 64'd0);
    @(negedge clk); @(negedge clk);
    en_v = 4'b0; rst = 1'b0;
    @(negedge clk);

    do_div(0, 1'b0, 64'd100, 64'd7, 33, 64'd14, 64'd2, "u100/7");
    do_div(0, 1'b1, 64'hFFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFD, 64'hFFFF_FFFF, "s-7/2");
    do_div(0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 33, 64'h8000_0000, 64'd0, "sMIN/-1");
    do_div(0, 1'b0, 64'h1234, 64'd0, 1, 64'hFFFF_FFFF, 64'h1234, "div0 early");
    do_div(1, 1'b0, 64'h1234, 64'd0, 33, 64'hFFFF_FFFF, 64'h1234, "div0 full");
    do_div(1, 1'b0, 64'd3, 64'd10, 33, 64'd0, 64'd3, "3/10 no early");
    do_div(0, 1'b0, 64'd3, 64'd10, 1, 64'd0, 64'd3, "3/10 early");
    do_div(0, 1'b1, 64'hFFFF_FFFD, 64'd10, 1, 64'd0, 64'hFFFF_FFFD, "s-3/10 early");
    do_div(0, 1'b0, 64'h8000_0000, 64'd3, 33, 64'h2AAA_AAAA, 64'd2, "u80000000/3");

    // Flush during cycle 10 of a running divide.
    cur = 0; sg = 1'b0; a32 = 32'd100; b32 = 32'd7; en_v = 4'b0001;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("flush pre calc stall", {63'b0, st0}, 64'd1);
    fl = 1'b1; en_v = 4'b0;
    @(posedge clk); @(negedge clk);
    fl = 1'b0; #1;
    chk("flush idle stall", {63'b0, st0}, 64'd0);
    chk("flush quotient held", {32'b0, q0}, 64'h2AAA_AAAA);
    chk("flush remainder held", {32'b0, r0}, 64'd2);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (rd0) seen = 1'b1; end
    chk("flush no ready", {63'b0, seen}, 64'd0);

    // Flush on the same cycle as a request in IDLE must not accept it.
    en_v = 4'b0001; fl = 1'b1; #1;
    chk("flush+en stall", {63'b0, st0}, 64'd0);
    @(posedge clk); @(negedge clk);
    en_v = 4'b0; fl = 1'b0; #1;
    chk("flush+en not calc", {63'b0, st0}, 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (rd0) seen = 1'b1; end
    chk("flush+en no ready", {63'b0, seen}, 64'd0);

    do_div(0, 1'b0, 64'd50, 64'd5, 33, 64'd10, 64'd0, "u50/5");

    do_div(2, 1'b0, 64'd100, 64'd7, 17, 64'd14, 64'd2, "r4 u100/7");
    do_div(2, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 17, 64'h8000_0000, 64'd0, "r4 sMIN/-1");
    for (int i = 0; i < 10; i++) begin
      rs = 1'(i & 1);
      ra = $urandom;
      rb = (i % 3 == 0) ? $urandom : 32'($urandom_range(1, 5000));
      if (i % 4 == 1) rb = -rb;
      if (i == 7) rb = 32'd0;
      ref_div(rs, ra, rb, rq, rr, rl);
      do_div(2, rs, {32'b0, ra}, {32'b0, rb}, rl, {32'b0, rq}, {32'b0, rr}, "r4 rand");
    end

    do_div(3, 1'b0, 64'd100, 64'd7, 65, 64'd14, 64'd2, "w64 u100/7");
    do_div(3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 65, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, "w64 max/16");
    do_div(3, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, "w64 s-100/7");

    // Asynchronous reset in the middle of CALC.
    cur = 0; sg = 1'b0; a32 = 32'd100; b32 = 32'd7; en_v = 4'b0001;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst pre calc stall", {63'b0, st0}, 64'd1);
    rst = 1'b1; #1;
    chk("rst mid quotient", {32'b0, q0}, 64'd0);
    chk("rst mid remainder", {32'b0, r0}, 64'd0);
    chk("rst mid ready", {63'b0, rd0}, 64'd0);
    chk("rst mid stall", {63'b0, st0}, 64'd0);
    @(negedge clk);
    rst = 1'b0; en_v = 4'b0; #1;
    chk("rst release idle", {63'b0, st0}, 64'd0);
    @(negedge clk);
    do_div(0, 1'b0, 64'd100, 64'd7, 33, 64'd14, 64'd2, "post rst u100/7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
